// File: rtl/cv32e40x_pkg.sv
// Shared types for the Zbc carry-less multiply sequencer.
// Optional early termination is enabled with CV32E40X_CLMUL_EARLY_TERM_EN (see cv32e40x_clmul_seq).
package cv32e40x_pkg;

    // Operator select from the decoder; 2'b11 is unused and handled as CLMUL
    typedef enum logic [1:0] {
        CLMUL  = 2'b00,
        CLMULH = 2'b01,
        CLMULR = 2'b10
    } clmul_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } clmul_state_e;

    localparam int unsigned CLMUL_XLEN = 32;

    // Only power-of-two slices that divide 32 evenly and keep the XOR array small
    function automatic bit clmul_bpc_legal(int unsigned bpc);
        return (bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8);
    endfunction

endpackage

// File: rtl/cv32e40x_clmul_step.sv
// One carry-less multiply step: XORs BITS_PER_CYCLE shifted copies of opa
// into the 64-bit accumulator, selected by the current low bits of opb.
module cv32e40x_clmul_step #(
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic [31:0]               opa,
    input  logic [BITS_PER_CYCLE-1:0] opb_bits,
    input  logic [5:0]                shift_base,
    input  logic [63:0]               acc,
    output logic [63:0]               acc_nxt
);

    logic [BITS_PER_CYCLE-1:0][63:0] pp;

    // One partial product per consumed bit of opb
    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_pp
        assign pp[k] = opb_bits[k] ? ({32'b0, opa} << (shift_base + 6'(k))) : 64'b0;
    end

    // Fold all partial products into the running accumulator
    always_comb begin
        acc_nxt = acc;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            acc_nxt = acc_nxt ^ pp[k];
        end
    end

endmodule

// File: rtl/cv32e40x_clmul_seq.sv
// Iterative carry-less multiplier (clmul/clmulh/clmulr) beside the EX ALU.
// Consumes BITS_PER_CYCLE bits of rs2 per BUSY cycle into a 64-bit accumulator.
// Define CV32E40X_CLMUL_EARLY_TERM_EN to finish as soon as the remaining rs2
// bits are all zero; otherwise latency is fixed.
module cv32e40x_clmul_seq
    import cv32e40x_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [1:0]  op_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        kill_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] result_o,
    output logic        busy_o
);

    localparam int unsigned NSTEPS   = CLMUL_XLEN / BITS_PER_CYCLE;
    localparam int unsigned CNT_W    = $clog2(NSTEPS);
    localparam int unsigned LOG2_BPC = $clog2(BITS_PER_CYCLE);

    if (!clmul_bpc_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
        $fatal(1, "cv32e40x_clmul_seq: BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    clmul_state_e     state_q, state_d;
    clmul_op_e        op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      opa_q, opb_q, opb_rem;
    logic [63:0]      acc_q, acc_nxt;
    logic [5:0]       shift_base;
    logic [31:0]      res_sel;
    logic             accept, last_step;

    assign accept     = valid_i && ready_o && !kill_i;
    assign last_step  = (cnt_q == CNT_W'(NSTEPS - 1));
    assign shift_base = 6'(cnt_q) << LOG2_BPC;
    assign opb_rem    = opb_q >> BITS_PER_CYCLE;

    cv32e40x_clmul_step #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .opa        (opa_q),
        .opb_bits   (opb_q[BITS_PER_CYCLE-1:0]),
        .shift_base (shift_base),
        .acc        (acc_q),
        .acc_nxt    (acc_nxt)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; kill overrides everything
    always_comb begin
        state_d = state_q;
        if (kill_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
`ifdef CV32E40X_CLMUL_EARLY_TERM_EN
                        state_d = (op_b_i == 32'b0) ? DONE : BUSY;
`else
                        state_d = BUSY;
`endif
                    end
                end
                BUSY: begin
`ifdef CV32E40X_CLMUL_EARLY_TERM_EN
                    if (last_step || (opb_rem == 32'b0)) state_d = DONE;
`else
                    if (last_step) state_d = DONE;
`endif
                end
                DONE: begin
                    if (ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from the current state; result gated by valid
    always_comb begin
        ready_o  = (state_q == IDLE);
        busy_o   = (state_q != IDLE);
        valid_o  = (state_q == DONE);
        result_o = valid_o ? res_sel : 32'b0;
    end

    // Word select from the 64-bit product
    always_comb begin
        case (op_q)
            CLMULH:  res_sel = acc_q[63:32];
            CLMULR:  res_sel = acc_q[62:31];
            default: res_sel = acc_q[31:0];
        endcase
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= CLMUL;
            opa_q <= 32'b0;
            opb_q <= 32'b0;
            acc_q <= 64'b0;
            cnt_q <= '0;
        end else if (kill_i) begin
            acc_q <= 64'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q  <= clmul_op_e'(op_i);
                        opa_q <= op_a_i;
                        opb_q <= op_b_i;
                        acc_q <= 64'b0;
                        cnt_q <= '0;
                    end
                end
                BUSY: begin
                    acc_q <= acc_nxt;
                    opb_q <= opb_rem;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Reserved operator encoding should never be issued
    a_op_legal: assert property (@(posedge clk) disable iff (rst)
        accept |-> (op_i != 2'b11))
        else $error("cv32e40x_clmul_seq: reserved op encoding 2'b11 issued");

    // A presented result holds until consumed or flushed
    a_result_hold: assert property (@(posedge clk) disable iff (rst)
        (valid_o && !ready_i && !kill_i) |=> (valid_o && $stable(result_o)))
        else $error("cv32e40x_clmul_seq: result dropped or changed while stalled");

endmodule

// File: tb/tb_cv32e40x_clmul_seq.sv
// Self-checking bench for cv32e40x_clmul_seq (BITS_PER_CYCLE=4).
// Expected latencies follow CV32E40X_CLMUL_EARLY_TERM_EN when it is defined.
module tb_cv32e40x_clmul_seq;
    import cv32e40x_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_o, kill_i, valid_o, ready_i, busy_o;
    logic [1:0]  op_i;
    logic [31:0] op_a_i, op_b_i, result_o;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] sb_q[$];

    cv32e40x_clmul_seq #(.BITS_PER_CYCLE(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .kill_i   (kill_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Bit-serial reference product, independent of slice width
    function automatic logic [31:0] clmul_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'b0;
        for (int i = 0; i < 32; i++) if (b[i]) p ^= ({32'b0, a} << i);
        case (op)
            2'b01:   return p[63:32];
            2'b10:   return p[62:31];
            default: return p[31:0];
        endcase
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef CV32E40X_CLMUL_EARLY_TERM_EN
        int msb;
        if (b == 32'b0) return 1;
        msb = 0;
        for (int i = 0; i < 32; i++) if (b[i]) msb = i;
        return 1 + (msb + 4) / 4;
`else
        return 9;
`endif
    endfunction

    // Issue one op, measure latency, optionally stall the consumer, then consume
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int hold, input string name);
        int lat;
        logic [31:0] want;
        lat = 0;
        @(negedge clk);
        valid_i = 1'b1; op_i = op; op_a_i = a; op_b_i = b;
        sb_q.push_back(exp);
        @(posedge clk);
        #1 valid_i = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (valid_o) begin
                lat = i;
                break;
            end
        end
        want = sb_q.pop_front();
        check({name, " latency"}, 32'(lat), 32'(exp_lat(b)));
        if (lat != 0) begin
            check({name, " result"}, result_o, want);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check({name, " hold valid"}, 32'(valid_o), 32'd1);
                check({name, " hold result"}, result_o, want);
                check({name, " hold ready"}, 32'(ready_o), 32'd0);
            end
            ready_i = 1'b1;
            check({name, " ready in consume"}, 32'(ready_o), 32'd0);
            @(posedge clk);
            #1 ready_i = 1'b0;
            check({name, " idle after consume"}, 32'(busy_o), 32'd0);
            check({name, " result cleared"}, result_o, 32'd0);
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b0;
        op_i = 2'b00; op_a_i = 32'b0; op_b_i = 32'b0;

        tbl.push_back('{2'b00, 32'h0000_0003, 32'h0000_0003, 32'h0000_0005});
        tbl.push_back('{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
        tbl.push_back('{2'b10, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000});
        tbl.push_back('{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555});
        tbl.push_back('{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hAAAA_AAAA});
        tbl.push_back('{2'b00, 32'h0000_0005, 32'h0000_0006, 32'h0000_001E});
        tbl.push_back('{2'b00, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000});
        tbl.push_back('{2'b01, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000});
        tbl.push_back('{2'b00, 32'h1234_5678, 32'h0000_0001, 32'h1234_5678});
        tbl.push_back('{2'b10, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001});
        tbl.push_back('{2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF});
        tbl.push_back('{2'b10, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF});
        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v.op  = 2'($urandom_range(0, 2));
            v.a   = $urandom;
            v.b   = $urandom >> $urandom_range(0, 31);
            v.exp = clmul_ref(v.op, v.a, v.b);
            tbl.push_back(v);
        end

        // Reset values while reset is held
        repeat (2) @(negedge clk);
        check("reset ready", 32'(ready_o), 32'd1);
        check("reset valid", 32'(valid_o), 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset result", result_o, 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, 0, $sformatf("vec%0d", i));

        // Consumer stall: output must hold
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5555_5555, 5, "stall clmulh");

        // Kill in the third BUSY cycle
        @(negedge clk);
        valid_i = 1'b1; op_i = 2'b00; op_a_i = 32'h0000_1234; op_b_i = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 valid_i = 1'b0;
        repeat (3) @(negedge clk);
        kill_i = 1'b1;
        @(posedge clk);
        #1 kill_i = 1'b0;
        check("kill busy", 32'(busy_o), 32'd0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        check("kill no valid", 32'(seen), 32'd0);
        run_op(2'b00, 32'h0000_0005, 32'h0000_0006, 32'h0000_001E, 0, "after kill");

        // Kill while the result is presented
        @(negedge clk);
        valid_i = 1'b1; op_i = 2'b00; op_a_i = 32'h3; op_b_i = 32'h3;
        @(posedge clk);
        #1 valid_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("done kill reached", 32'(seen), 32'd1);
        kill_i = 1'b1;
        @(posedge clk);
        #1 kill_i = 1'b0;
        @(negedge clk);
        check("done kill valid", 32'(valid_o), 32'd0);
        check("done kill result", result_o, 32'd0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        valid_i = 1'b1; op_i = 2'b01; op_a_i = 32'hCAFE_F00D; op_b_i = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 valid_i = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", 32'(busy_o), 32'd0);
        check("async rst ready", 32'(ready_o), 32'd1);
        check("async rst valid", 32'(valid_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        check("rst no valid", 32'(seen), 32'd0);

        // Valid together with kill in IDLE is not accepted
        @(negedge clk);
        valid_i = 1'b1; kill_i = 1'b1; op_i = 2'b00; op_a_i = 32'h7; op_b_i = 32'h7;
        @(posedge clk);
        #1 valid_i = 1'b0; kill_i = 1'b0;
        check("valid+kill busy", 32'(busy_o), 32'd0);
        check("valid+kill ready", 32'(ready_o), 32'd1);

        run_op(2'b00, 32'h0000_0007, 32'h0000_0007, clmul_ref(2'b00, 32'h7, 32'h7), 0, "final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
